rng_word_collector: RTL and testbench

- Consumer end of the ring-oscillator entropy path.
- Takes the sampled bit stream from ring_osc_sampler, optionally removes bias with a von Neumann corrector, and runs a repetition-count health test on the raw bits.
- Packs the resulting bits into words and hands them downstream on a valid/ready interface.
- Sits between the sampler and any word consumer (UART dump, seven-segment display, hash core).

---
 rtl/rng_pkg.sv | 25 ++
 rtl/rng_rct_monitor.sv | 67 ++++++
 rtl/rng_word_collector.sv | 146 ++++++++++++++
 tb/tb_rng_word_collector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
//==============================================================================
// Module   : rng_pkg
// Purpose  : Shared types and default sizes for the ring-oscillator entropy
//            consumer path (word collector and its health monitors).
// Contents : pair_state_t          - von Neumann pair tracker states
//            RNG_WORD_WIDTH_DEFAULT - default bits per output word
//            RCT_CUTOFF_DEFAULT     - default repetition-count cutoff
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package rng_pkg;

  localparam int RNG_WORD_WIDTH_DEFAULT = 32;
  localparam int RCT_CUTOFF_DEFAULT     = 32;

  typedef enum logic [0:0] {
    PAIR_EMPTY      = 1'b0,
    PAIR_HAVE_FIRST = 1'b1
  } pair_state_t;

endpackage : rng_pkg

`default_nettype wire

// File: rtl/rng_rct_monitor.sv
//==============================================================================
// Module   : rng_rct_monitor
// Purpose  : Repetition-count health test on a raw entropy bit stream. Tracks
//            the length of the current run of identical accepted bits and
//            raises a sticky failure flag when the run reaches RCT_CUTOFF.
// Ports    : clk       in  system clock
//            rst       in  synchronous active-high reset
//            bit_in    in  raw bit under test
//            bit_valid in  bit_in is accepted on cycles where this is 1
//            fail      out sticky failure flag (cleared only by rst)
//            fail_set  out combinational: fail rises at the coming edge, so a
//                          consumer can flush state on that same edge
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rng_rct_monitor
  import rng_pkg::*;
#(
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  output logic fail,
  output logic fail_set
);

  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  logic [RUN_W-1:0] r_run_len;
  logic             r_prev_bit;
  logic             r_fail;
  logic             w_repeat;

  // A zero run length means nothing accepted since reset, so the first bit
  // always starts a fresh run regardless of r_prev_bit.
  assign w_repeat = (r_run_len != '0) && (bit_in == r_prev_bit);
  assign fail_set = bit_valid && !r_fail && w_repeat &&
                    (r_run_len == RUN_W'(RCT_CUTOFF - 1));
  assign fail     = r_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_len  <= '0;
      r_prev_bit <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      if (bit_valid) begin
        r_prev_bit <= bit_in;
        if (!w_repeat) begin
          r_run_len <= RUN_W'(1);
        end else if (r_run_len != RUN_W'(RCT_CUTOFF)) begin
          r_run_len <= r_run_len + 1'b1;
        end
      end
      if (fail_set) begin
        r_fail <= 1'b1;
      end
    end
  end

endmodule : rng_rct_monitor

`default_nettype wire

// File: rtl/rng_word_collector.sv
//==============================================================================
// Module   : rng_word_collector
// Purpose  : Consumer end of the ring-oscillator entropy path. Optionally
//            debiases the raw bit stream (von Neumann), runs a repetition-count
//            health test on raw bits, packs bits MSB-first into words and
//            offers them on a valid/ready interface.
// Macro    : RNG_DEBIAS_EN - when defined, the von Neumann pair FSM is built;
//            when undefined, every valid raw bit is collected directly.
// Ports    : clk           in  system clock
//            rst           in  synchronous active-high reset
//            rng_bit       in  raw entropy bit (clk domain)
//            bit_valid     in  rng_bit strobe
//            dout          out assembled word
//            dout_valid    out dout holds an unconsumed word
//            dout_ready    in  downstream accepts dout
//            health_fail   out sticky repetition-count failure
//            dropped_count out saturating count of bits lost to backpressure
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rng_word_collector
  import rng_pkg::*;
#(
  parameter int WORD_WIDTH     = RNG_WORD_WIDTH_DEFAULT,
  parameter int RCT_CUTOFF     = RCT_CUTOFF_DEFAULT,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rng_bit,
  input  logic                      bit_valid,
  output logic [WORD_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      health_fail,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0]     r_shift;
  logic [CNT_W-1:0]          r_bit_count;
  logic [WORD_WIDTH-1:0]     r_dout;
  logic                      r_dout_valid;
  logic [DROP_CNT_WIDTH-1:0] r_drop;

  logic w_emit;
  logic w_emit_bit;
  logic w_full;
  logic w_slot_free;
  logic w_xfer;
  logic w_fail_set;

`ifdef RNG_DEBIAS_EN
  pair_state_t r_pair_state;
  logic        r_first_bit;

  // Unequal pair emits its first bit: 10 -> 1, 01 -> 0.
  assign w_emit     = bit_valid && (r_pair_state == PAIR_HAVE_FIRST) &&
                      (r_first_bit != rng_bit);
  assign w_emit_bit = r_first_bit;
`else
  assign w_emit     = bit_valid;
  assign w_emit_bit = rng_bit;
`endif

  assign w_full      = (r_bit_count == CNT_W'(WORD_WIDTH));
  assign w_slot_free = !r_dout_valid || dout_ready;
  assign w_xfer      = w_full && w_slot_free;

  rng_rct_monitor #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (rng_bit),
    .bit_valid (bit_valid),
    .fail      (health_fail),
    .fail_set  (w_fail_set)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bit_count  <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_drop       <= '0;
`ifdef RNG_DEBIAS_EN
      r_pair_state <= PAIR_EMPTY;
      r_first_bit  <= 1'b0;
`endif
    end else if (health_fail || w_fail_set) begin
      // Failed source: flush everything pending and stay quiet until rst.
      r_dout_valid <= 1'b0;
      r_bit_count  <= '0;
`ifdef RNG_DEBIAS_EN
      r_pair_state <= PAIR_EMPTY;
`endif
    end else begin
`ifdef RNG_DEBIAS_EN
      if (bit_valid) begin
        case (r_pair_state)
          PAIR_EMPTY: begin
            r_first_bit  <= rng_bit;
            r_pair_state <= PAIR_HAVE_FIRST;
          end
          default: r_pair_state <= PAIR_EMPTY;
        endcase
      end
`endif
      if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      if (w_xfer) begin
        // Word moves out; a bit emitted this same cycle starts the next word.
        // Stale upper shift bits are pushed out before that word completes.
        r_dout       <= r_shift;
        r_dout_valid <= 1'b1;
        if (w_emit) begin
          r_shift     <= {r_shift[WORD_WIDTH-2:0], w_emit_bit};
          r_bit_count <= CNT_W'(1);
        end else begin
          r_bit_count <= '0;
        end
      end else if (w_full) begin
        if (w_emit && (r_drop != '1)) begin
          r_drop <= r_drop + 1'b1;
        end
      end else if (w_emit) begin
        r_shift     <= {r_shift[WORD_WIDTH-2:0], w_emit_bit};
        r_bit_count <= r_bit_count + 1'b1;
      end
    end
  end

  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign dropped_count = r_drop;

endmodule : rng_word_collector

`default_nettype wire

// File: tb/tb_rng_word_collector.sv
//==============================================================================
// Module   : tb_rng_word_collector
// Purpose  : Directed self-checking bench for rng_word_collector with
//            WORD_WIDTH=8, RCT_CUTOFF=8. Emitted bits are produced as raw
//            pairs when RNG_DEBIAS_EN is defined, or as raw bits otherwise.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rng_word_collector;

  localparam int WW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          rng_bit;
  logic          bit_valid;
  logic [WW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          health_fail;
  logic [DW-1:0] dropped_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid_cycles = 0;
  logic [WW-1:0] words[$];

  rng_word_collector #(
    .WORD_WIDTH     (WW),
    .RCT_CUTOFF     (8),
    .DROP_CNT_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rng_bit       (rng_bit),
    .bit_valid     (bit_valid),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .health_fail   (health_fail),
    .dropped_count (dropped_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so negedge sees the values that the
  // next posedge will act on.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      n_valid_cycles++;
      if (dout_ready) words.push_back(dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed_raw(input logic b);
    rng_bit   = b;
    bit_valid = 1'b1;
    tick();
  endtask

  task automatic feed_emit(input logic b);
`ifdef RNG_DEBIAS_EN
    feed_raw(b);
    feed_raw(~b);
`else
    feed_raw(b);
`endif
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) feed_emit(v[i]);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    words.delete();
    n_valid_cycles = 0;
  endtask

  initial begin
    rst        = 1'b1;
    rng_bit    = 1'b0;
    bit_valid  = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("reset_dout",        32'(dout),          32'h0);
    check("reset_dout_valid",  32'(dout_valid),    32'h0);
    check("reset_health_fail", 32'(health_fail),   32'h0);
    check("reset_dropped",     32'(dropped_count), 32'h0);
    do_reset();

    // Basic word: bits 1,0,1,1,0,0,1,0 -> B2, valid exactly two edges later
    dout_ready = 1'b1;
    feed_byte(8'hB2);
    bit_valid = 1'b0;
    check("basic_valid_n1", 32'(dout_valid), 32'h0);
    tick();
    check("basic_valid_n2", 32'(dout_valid), 32'h1);
    check("basic_dout",     32'(dout),       32'hB2);
    tick();
    check("basic_valid_off", 32'(dout_valid), 32'h0);
    idle(4);
    check("basic_words",   32'(words.size()), 32'd1);
    check("basic_vcycles", 32'(n_valid_cycles), 32'd1);
    check("basic_dropped", 32'(dropped_count), 32'h0);

    // Discarded pairs (debias) / gapped bit_valid (direct) -> same word
    do_reset();
    dout_ready = 1'b1;
`ifdef RNG_DEBIAS_EN
    begin
      logic [7:0] pat;
      pat = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
        feed_raw(i[0]);
        feed_raw(i[0]);
        feed_emit(pat[i]);
      end
    end
`else
    begin
      logic [7:0] pat;
      pat = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
        feed_emit(pat[i]);
        idle(1);
      end
    end
`endif
    idle(5);
    check("discard_words", 32'(words.size()), 32'd1);
    check("discard_dout",  32'(words[0]),     32'hB2);

    // Backpressure: 24 bits, ready low
    do_reset();
    dout_ready = 1'b0;
    feed_byte(8'hC6);
    feed_byte(8'h39);
    feed_byte(8'h5A);
    idle(3);
    check("bp_valid",   32'(dout_valid),    32'h1);
    check("bp_dout",    32'(dout),          32'hC6);
    check("bp_dropped", 32'(dropped_count), 32'd8);
    idle(3);
    check("bp_hold", 32'(dout), 32'hC6);
    dout_ready = 1'b1;
    tick();
    check("bp_second_valid", 32'(dout_valid), 32'h1);
    check("bp_second_dout",  32'(dout),       32'h39);
    tick();
    check("bp_drained", 32'(dout_valid), 32'h0);
    idle(3);
    check("bp_words", 32'(words.size()), 32'd2);
    check("bp_w0",    32'(words[0]),     32'hC6);
    check("bp_w1",    32'(words[1]),     32'h39);
    check("bp_dropped_after", 32'(dropped_count), 32'd8);

    // Near miss: runs of 7 ones never trip
    do_reset();
    dout_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 7; k++) feed_raw(1'b1);
      feed_raw(1'b0);
    end
    idle(2);
    check("nearmiss_health", 32'(health_fail), 32'h0);

    // Health trip: pending word, then 8 raw ones
    do_reset();
    dout_ready = 1'b0;
    feed_byte(8'hA4);
    feed_raw(1'b0);
    for (int k = 0; k < 7; k++) feed_raw(1'b1);
    check("trip_pre_health", 32'(health_fail), 32'h0);
    check("trip_pre_valid",  32'(dout_valid),  32'h1);
    check("trip_pre_dout",   32'(dout),        32'hA4);
    feed_raw(1'b1);
    check("trip_health", 32'(health_fail), 32'h1);
    check("trip_valid",  32'(dout_valid),  32'h0);
    bit_valid = 1'b0;
    words.delete();
    dout_ready = 1'b1;
    feed_byte(8'h55);
    feed_byte(8'h55);
    idle(4);
    check("trip_no_words",    32'(words.size()), 32'd0);
    check("trip_valid_after", 32'(dout_valid),   32'h0);
    check("trip_sticky",      32'(health_fail),  32'h1);
    do_reset();
    check("trip_rst_clears", 32'(health_fail), 32'h0);

    // Reset mid-word
    dout_ready = 1'b1;
    feed_emit(1'b1);
    feed_emit(1'b1);
    feed_emit(1'b1);
    feed_emit(1'b0);
    feed_emit(1'b0);
`ifdef RNG_DEBIAS_EN
    feed_raw(1'b1);
`endif
    do_reset();
    dout_ready = 1'b1;
    feed_byte(8'hAB);
    idle(4);
    check("midrst_words",   32'(words.size()),  32'd1);
    check("midrst_dout",    32'(words[0]),      32'hAB);
    check("midrst_dropped", 32'(dropped_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rng_word_collector

`default_nettype wire
